// File: rtl/cbus_axi_bridge_pkg.sv
// Cache-bus request/response types, AXI3 master channel bundles and the bridge state encoding.
package cbus_axi_bridge_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = DATA_W / 8;
    localparam int LEN_W    = 4;
    localparam int SIZE_W   = 3;
    localparam int AXI_ID_W = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic              ready;
        logic              last;
        logic [DATA_W-1:0] data;
        logic              okay;
    } cbus_resp_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] arid;
        logic [ADDR_W-1:0]   araddr;
        logic [LEN_W-1:0]    arlen;
        logic [SIZE_W-1:0]   arsize;
        logic [1:0]          arburst;
        logic                arvalid;
        logic                rready;
        logic [AXI_ID_W-1:0] awid;
        logic [ADDR_W-1:0]   awaddr;
        logic [LEN_W-1:0]    awlen;
        logic [SIZE_W-1:0]   awsize;
        logic [1:0]          awburst;
        logic                awvalid;
        logic [AXI_ID_W-1:0] wid;
        logic [DATA_W-1:0]   wdata;
        logic [STRB_W-1:0]   wstrb;
        logic                wlast;
        logic                wvalid;
        logic                bready;
    } axi_req_t;

    typedef struct packed {
        logic                arready;
        logic [AXI_ID_W-1:0] rid;
        logic [DATA_W-1:0]   rdata;
        logic [1:0]          rresp;
        logic                rlast;
        logic                rvalid;
        logic                awready;
        logic                wready;
        logic [AXI_ID_W-1:0] bid;
        logic [1:0]          bresp;
        logic                bvalid;
    } axi_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } bridge_state_t;

endpackage

// File: rtl/cbus_axi_bridge.sv
// Purpose: converts one cache-bus read or write burst at a time into an AXI3 master transaction.
// Latency: AR/AW one cycle after creq.valid; read beats pass through combinationally in R.
// Backpressure: AXI readies stall the FSM; upstream sees cresp.ready only on accepted beats.
module cbus_axi_bridge
    import cbus_axi_bridge_pkg::*;
#(
    parameter logic [AXI_ID_W-1:0] AXI_ID = '0
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output axi_req_t   axi_req,
    input  axi_resp_t  axi_resp
);

    bridge_state_t    state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             wlast_w;

    // IDs of returning beats are irrelevant with a single outstanding transaction.
    logic unused_ids;
    assign unused_ids = ^{axi_resp.rid, axi_resp.bid};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wlast_w = (cnt_q == creq.len);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cresp   = '0;
        axi_req = '0;

        axi_req.arid    = AXI_ID;
        axi_req.araddr  = creq.addr;
        axi_req.arlen   = creq.len;
        axi_req.arsize  = creq.size;
        axi_req.arburst = AXI_BURST_INCR;
        axi_req.awid    = AXI_ID;
        axi_req.awaddr  = creq.addr;
        axi_req.awlen   = creq.len;
        axi_req.awsize  = creq.size;
        axi_req.awburst = AXI_BURST_INCR;
        axi_req.wid     = AXI_ID;
        axi_req.wdata   = creq.data;
        axi_req.wstrb   = creq.strobe;

        unique case (state_q)
            ST_IDLE: begin
                if (creq.valid) begin
                    state_d = creq.is_write ? ST_AW : ST_AR;
                end
            end
            ST_AR: begin
                axi_req.arvalid = 1'b1;
                if (axi_resp.arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                axi_req.rready = 1'b1;
                cresp.ready    = axi_resp.rvalid;
                cresp.data     = axi_resp.rdata;
                cresp.last     = axi_resp.rlast;
                cresp.okay     = (axi_resp.rresp == AXI_RESP_OKAY);
                if (axi_resp.rvalid && axi_resp.rlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_AW: begin
                axi_req.awvalid = 1'b1;
                cnt_d           = '0;
                if (axi_resp.awready) begin
                    state_d = ST_W;
                end
            end
            ST_W: begin
                axi_req.wvalid = 1'b1;
                axi_req.wlast  = wlast_w;
                // The last data beat is acknowledged upstream only once B returns.
                if (axi_resp.wready) begin
                    if (wlast_w) begin
                        state_d = ST_B;
                    end else begin
                        cresp.ready = 1'b1;
                        cresp.okay  = 1'b1;
                        cnt_d       = cnt_q + 1'b1;
                    end
                end
            end
            ST_B: begin
                axi_req.bready = 1'b1;
                if (axi_resp.bvalid) begin
                    cresp.ready = 1'b1;
                    cresp.last  = 1'b1;
                    cresp.okay  = (axi_resp.bresp == AXI_RESP_OKAY);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/cbus_axi_bridge.md
# cbus_axi_bridge

Protocol converter sitting directly downstream of the CPU top level. It consumes the single arbitrated, address-translated cache-bus request stream (`cbus_req_t`/`cbus_resp_t`) and drives an AXI3 master port toward the SoC interconnect. It handles one transaction at a time, either a read burst or a write burst, and has no outstanding-transaction overlap.

## Interface
- `AXI_ID`, default 0: constant ID driven on `arid`/`awid`/`wid`. `rid`/`bid` are ignored.
- `clk` in, 1: clock, all logic rising-edge.
- `resetn` in, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `creq` in, `cbus_req_t`: `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`.
- `cresp` out, `cbus_resp_t`: `ready`, `last`, `data`, `okay`.
- `axi_req` out, `axi_req_t`: AR, AW and W channel payloads and valids, plus `rready` and `bready`.
- `axi_resp` in, `axi_resp_t`: `arready`, `awready`, `wready`, and the R and B channel payloads and valids.

## Operation
- cbus contract, upstream side:
  - `creq` is held stable from `valid` rising until the cycle `cresp.ready & cresp.last`.
  - `creq.data`/`strobe` advance to the next beat in the cycle after each `cresp.ready`.
- States: IDLE, AR, R, AW, W, B.
- IDLE:
  - `creq.valid & !is_write` → AR.
  - `creq.valid & is_write` → AW.
  - All AXI valids and readies are 0.
- AR:
  - `arvalid=1`, `araddr=creq.addr`, `arsize=creq.size`, `arlen=creq.len`, `arburst=INCR (2'b01)`.
  - `arready` → R.
- R:
  - `rready=1`.
  - `cresp.ready=rvalid`, `cresp.data=rdata`, `cresp.last=rlast`, `cresp.okay=(rresp==0)`.
  - `rvalid & rlast` → IDLE.
- AW:
  - `awvalid=1`, same address and control fields as AR.
  - `awready` → W.
  - Beat counter is cleared.
- W:
  - `wvalid=1`, `wdata=creq.data`, `wstrb=creq.strobe`, `wlast=(cnt==creq.len)`.
  - On a `wready` handshake that is not the last beat: `cresp.ready=1`, `cresp.last=0`, `cnt++`.
  - On a `wready` handshake that is the last beat: → B, and `cresp.ready` stays 0.
- B:
  - `bready=1`.
  - On `bvalid`: `cresp.ready=1`, `cresp.last=1`, `cresp.okay=(bresp==0)`, → IDLE.
  - The final write completion is therefore reported only after the write response returns.
- Beat counter is 4 bits, matching the AXI3 `len` width, and never wraps: `len=15` gives 16 beats, and the counter reaches 15 at `wlast`.
- Outside R, W and B, `cresp` is all zero.
- `creq.valid` dropping mid-transaction is a protocol violation. Behaviour is undefined, and the bench flags it.

## Timing
- Reset values: state=IDLE, cnt=0. All AXI valids and readies, and all `cresp` fields, are 0.
- Reset asserted mid-burst aborts the transaction immediately. No AXI cleanup is attempted; the interconnect is reset together with the bridge.
- The state register changes only on clock edges. All AXI and `cresp` outputs are combinational from state, `creq` and the AXI inputs. This is a Moore state plus Mealy handshake qualifiers.
- Read latency: `creq.valid` at cycle 0 → `arvalid` at cycle 1 → first `cresp.ready` in the same cycle as the first `rvalid` in R.
- Back-to-back: the cycle after completion is spent in IDLE, so a new request's `arvalid`/`awvalid` appears two cycles after the previous `last`.
- `arvalid`, `awvalid` and `wvalid` stay asserted until their ready arrives. They are never withdrawn and never depend on the corresponding ready.
- A ready asserted in the same cycle as the state entry is a valid handshake.

## Structure
- Put `axi_req_t`, `axi_resp_t` and the constants `AXI_BURST_INCR` and `AXI_RESP_OKAY` in the shared bus package beside the cbus types.
- Put the state enum `bridge_state_t` in the same package.
- No sub-module: a single FSM plus the beat counter.

## Test plan
- Single read: addr `0x1fc0_0000`, len 0, `rdata 0xdeadbeef` → one `cresp` beat with ready=1, last=1, data=`0xdeadbeef`, okay=1; back in IDLE the next cycle.
- 4-beat read with `arready` delayed 3 cycles and an `rvalid` gap after beat 2 → exactly 4 `cresp.ready` pulses, data in order, last only on beat 4.
- 4-beat write, `wready` toggling 1/0 → wlast only on beat 4; 3 early `cresp.ready` pulses; final ready+last only on `bvalid`, 5 cycles later.
- Write with `bresp=2'b10` → final `cresp.okay=0`.
- `resetn` pulled low during W beat 2 → all outputs 0 immediately; after release, a fresh read completes normally.
- Read followed immediately by write → AW is issued exactly 2 cycles after the read's last, with `awid=AXI_ID` and `awburst=2'b01`.
